// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and fetch stage feeding a registered valid/ready slot to decode
module instruction_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] fetchAddr,
  input  logic [DATA_WIDTH-1:0] fetchInstr,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outInstr,
  output logic [ADDR_WIDTH-1:0] outPc,
  input  logic                  redirectValid,
  input  logic [ADDR_WIDTH-1:0] redirectTarget,
  input  logic                  trapValid,
  input  logic                  halt,
  output logic                  excMisaligned,
  output logic [ADDR_WIDTH-1:0] excAddr,
  output logic [31:0]           issueCount
);
  logic [ADDR_WIDTH-1:0] pc;
  logic advance, handshake, misaligned;
  assign fetchAddr = pc;
  assign handshake = outValid && outReady;
  assign advance = !outValid || outReady;
  assign misaligned = redirectTarget[1:0] != 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VECTOR;
      outValid <= 1'b0;
      outInstr <= NOP_INSTR;
      outPc <= '0;
      excMisaligned <= 1'b0;
      excAddr <= '0;
      issueCount <= '0;
    end else begin
      excMisaligned <= 1'b0;
      if (handshake && issueCount != 32'hFFFF_FFFF) issueCount <= issueCount + 32'd1;
      if (trapValid) begin
        pc <= TRAP_VECTOR;
        outValid <= 1'b0;
        outInstr <= NOP_INSTR;
      end else if (redirectValid) begin
        pc <= misaligned ? TRAP_VECTOR : redirectTarget;
        outValid <= 1'b0;
        if (misaligned) begin
          excMisaligned <= 1'b1;
          excAddr <= redirectTarget;
        end
      end else if (halt) begin
        if (handshake) outValid <= 1'b0;
      end else if (advance) begin
        outInstr <= fetchInstr;
        outPc <= pc;
        outValid <= 1'b1;
        pc <= pc + ADDR_WIDTH'(4);
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenario tests for the fetch stage
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] fetchAddr, fetchInstr, outInstr, outPc, redirectTarget, excAddr, issueCount;
  logic outValid, outReady, redirectValid, trapValid, halt, excMisaligned;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign fetchInstr = fetchAddr ^ 32'hA5A5_0000;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .fetchAddr(fetchAddr), .fetchInstr(fetchInstr),
    .outValid(outValid), .outReady(outReady), .outInstr(outInstr), .outPc(outPc),
    .redirectValid(redirectValid), .redirectTarget(redirectTarget), .trapValid(trapValid),
    .halt(halt), .excMisaligned(excMisaligned), .excAddr(excAddr), .issueCount(issueCount)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; outReady = 1'b0; redirectValid = 1'b0; redirectTarget = '0; trapValid = 1'b0; halt = 1'b0;
    step(); step();
    checks++; if (outValid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", outValid); end
    checks++; if (outInstr !== 32'h13) begin fails++; $display("FAIL reset_instr got %h want 00000013", outInstr); end
    checks++; if (outPc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 0", outPc); end
    checks++; if (fetchAddr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", fetchAddr); end
    checks++; if (excMisaligned !== 1'b0 || excAddr !== 32'h0) begin fails++; $display("FAIL reset_exc got %b/%h want 0/0", excMisaligned, excAddr); end
    checks++; if (issueCount !== 32'h0) begin fails++; $display("FAIL reset_count got %0d want 0", issueCount); end
  endtask

  task automatic test_fetch();
    rst = 1'b0; outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (outValid !== 1'b1) begin fails++; $display("FAIL fetch_valid[%0d] got %b want 1", i, outValid); end
      checks++; if (outPc !== 32'(i * 4)) begin fails++; $display("FAIL fetch_pc[%0d] got %h want %h", i, outPc, 32'(i * 4)); end
      checks++; if (outInstr !== (32'(i * 4) ^ 32'hA5A5_0000)) begin fails++; $display("FAIL fetch_instr[%0d] got %h want %h", i, outInstr, 32'(i * 4) ^ 32'hA5A5_0000); end
      checks++; if (issueCount !== 32'(i)) begin fails++; $display("FAIL fetch_count[%0d] got %0d want %0d", i, issueCount, i); end
    end
  endtask

  task automatic test_stall();
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (outPc !== 32'h8 || outInstr !== 32'hA5A5_0008 || outValid !== 1'b1) begin fails++; $display("FAIL stall_hold[%0d] got %h/%h/%b want 8/a5a50008/1", i, outPc, outInstr, outValid); end
      checks++; if (fetchAddr !== 32'hC) begin fails++; $display("FAIL stall_addr[%0d] got %h want c", i, fetchAddr); end
      checks++; if (issueCount !== 32'd2) begin fails++; $display("FAIL stall_count[%0d] got %0d want 2", i, issueCount); end
    end
    outReady = 1'b1;
    step();
    checks++; if (outPc !== 32'hC || outInstr !== 32'hA5A5_000C) begin fails++; $display("FAIL stall_release got %h/%h want c/a5a5000c", outPc, outInstr); end
    step();
    checks++; if (issueCount !== 32'd4) begin fails++; $display("FAIL stall_count_after got %0d want 4", issueCount); end
  endtask

  task automatic test_redirect();
    redirectValid = 1'b1; redirectTarget = 32'h40;
    step();
    redirectValid = 1'b0;
    checks++; if (outValid !== 1'b0 || fetchAddr !== 32'h40) begin fails++; $display("FAIL redir_flush got %b/%h want 0/40", outValid, fetchAddr); end
    checks++; if (issueCount !== 32'd5) begin fails++; $display("FAIL redir_count got %0d want 5", issueCount); end
    step();
    checks++; if (outValid !== 1'b1 || outPc !== 32'h40 || outInstr !== 32'hA5A5_0040) begin fails++; $display("FAIL redir_first got %b/%h/%h want 1/40/a5a50040", outValid, outPc, outInstr); end
    checks++; if (fetchAddr !== 32'h44) begin fails++; $display("FAIL redir_next got %h want 44", fetchAddr); end
  endtask

  task automatic test_misaligned();
    redirectValid = 1'b1; redirectTarget = 32'h42;
    step();
    redirectValid = 1'b0;
    checks++; if (excMisaligned !== 1'b1 || excAddr !== 32'h42) begin fails++; $display("FAIL mis_exc got %b/%h want 1/42", excMisaligned, excAddr); end
    checks++; if (fetchAddr !== 32'h100 || outValid !== 1'b0) begin fails++; $display("FAIL mis_trap got %h/%b want 100/0", fetchAddr, outValid); end
    step();
    checks++; if (excMisaligned !== 1'b0 || excAddr !== 32'h42) begin fails++; $display("FAIL mis_pulse got %b/%h want 0/42", excMisaligned, excAddr); end
    checks++; if (outPc !== 32'h100 || outValid !== 1'b1 || fetchAddr !== 32'h104) begin fails++; $display("FAIL mis_resume got %h/%b/%h want 100/1/104", outPc, outValid, fetchAddr); end
    checks++; if (issueCount !== 32'd6) begin fails++; $display("FAIL mis_count got %0d want 6", issueCount); end
  endtask

  task automatic test_trap();
    trapValid = 1'b1; redirectValid = 1'b1; redirectTarget = 32'h80;
    step();
    trapValid = 1'b0; redirectValid = 1'b0;
    checks++; if (fetchAddr !== 32'h100 || outValid !== 1'b0 || outInstr !== 32'h13) begin fails++; $display("FAIL trap_prio got %h/%b/%h want 100/0/00000013", fetchAddr, outValid, outInstr); end
    checks++; if (excMisaligned !== 1'b0 || issueCount !== 32'd7) begin fails++; $display("FAIL trap_side got %b/%0d want 0/7", excMisaligned, issueCount); end
    step();
    checks++; if (outPc !== 32'h100 || outInstr !== 32'hA5A5_0100 || outValid !== 1'b1) begin fails++; $display("FAIL trap_resume got %h/%h/%b want 100/a5a50100/1", outPc, outInstr, outValid); end
  endtask

  task automatic test_wrap();
    redirectValid = 1'b1; redirectTarget = 32'hFFFF_FFFC;
    step();
    redirectValid = 1'b0;
    checks++; if (fetchAddr !== 32'hFFFF_FFFC || excMisaligned !== 1'b0) begin fails++; $display("FAIL wrap_load got %h/%b want fffffffc/0", fetchAddr, excMisaligned); end
    step();
    checks++; if (fetchAddr !== 32'h0) begin fails++; $display("FAIL wrap_pc got %h want 0", fetchAddr); end
    checks++; if (outPc !== 32'hFFFF_FFFC || outInstr !== 32'h5A5A_FFFC) begin fails++; $display("FAIL wrap_slot got %h/%h want fffffffc/5a5afffc", outPc, outInstr); end
    checks++; if (issueCount !== 32'd8) begin fails++; $display("FAIL wrap_count got %0d want 8", issueCount); end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    step();
    checks++; if (outValid !== 1'b0 || fetchAddr !== 32'h0 || issueCount !== 32'd9) begin fails++; $display("FAIL halt_drain got %b/%h/%0d want 0/0/9", outValid, fetchAddr, issueCount); end
    step();
    checks++; if (outValid !== 1'b0 || fetchAddr !== 32'h0 || issueCount !== 32'd9) begin fails++; $display("FAIL halt_hold got %b/%h/%0d want 0/0/9", outValid, fetchAddr, issueCount); end
    halt = 1'b0;
    step();
    checks++; if (outValid !== 1'b1 || outPc !== 32'h0 || outInstr !== 32'hA5A5_0000 || fetchAddr !== 32'h4) begin fails++; $display("FAIL halt_resume got %b/%h/%h/%h want 1/0/a5a50000/4", outValid, outPc, outInstr, fetchAddr); end
    halt = 1'b1;
    step();
    rst = 1'b1;
    step();
    checks++; if (outValid !== 1'b0 || outInstr !== 32'h13 || outPc !== 32'h0) begin fails++; $display("FAIL halt_rst_slot got %b/%h/%h want 0/00000013/0", outValid, outInstr, outPc); end
    checks++; if (fetchAddr !== 32'h0 || issueCount !== 32'h0 || excAddr !== 32'h0) begin fails++; $display("FAIL halt_rst_state got %h/%0d/%h want 0/0/0", fetchAddr, issueCount, excAddr); end
    rst = 1'b0; halt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_misaligned();
    test_trap();
    test_wrap();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the Yu core; sits directly upstream of the instruction memory.
- Owns the program counter and drives the memory address. The memory returns the instruction combinationally in the same cycle.
- Registers the fetched instruction and its PC into a valid/ready output slot for decode.
- Handles branch/jump redirects, trap entry, halt and misaligned-target detection.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, instruction width.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect.
- NOP_INSTR, 32'h0000_0013, value held in outInstr when the slot is empty or after reset.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- fetchAddr  output  ADDR_WIDTH  address to instruction memory; combinationally equal to the pc register.
- fetchInstr  input  DATA_WIDTH  instruction returned by memory for fetchAddr, same cycle.
- outValid  output  1  output slot holds a valid instruction.
- outReady  input  1  decode accepts the slot this cycle.
- outInstr  output  DATA_WIDTH  registered instruction.
- outPc  output  ADDR_WIDTH  PC of outInstr.
- redirectValid  input  1  branch/jump taken; flush and load redirectTarget.
- redirectTarget  input  ADDR_WIDTH  new PC.
- trapValid  input  1  trap entry; flush and load TRAP_VECTOR.
- halt  input  1  stop issuing new fetches.
- excMisaligned  output  1  one-cycle pulse: redirect target not word aligned.
- excAddr  output  ADDR_WIDTH  offending target, captured with excMisaligned.
- issueCount  output  32  number of handshakes completed (outValid && outReady); saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset (rst=1 at clk edge) sets:
  - pc=RESET_VECTOR, outValid=0, outInstr=NOP_INSTR, outPc=0.
  - excMisaligned=0, excAddr=0, issueCount=0.
  - Reset has priority over every other input, including mid-redirect or mid-stall.
- advance = !outValid || outReady (slot empty, or being consumed this cycle).
- Priority per cycle: rst > trapValid > redirectValid > halt > normal fetch.
- trapValid=1:
  - pc<=TRAP_VECTOR, outValid<=0, outInstr<=NOP_INSTR.
  - No fetch is issued this cycle; any concurrent redirect is ignored.
- redirectValid=1 with redirectTarget[1:0]==0:
  - pc<=redirectTarget, outValid<=0 (flush).
  - The first instruction from the target appears in the slot on the following edge, so redirect-to-valid latency is 2 edges.
- redirectValid=1 with redirectTarget[1:0]!=0:
  - pc<=TRAP_VECTOR, outValid<=0, excMisaligned<=1 for exactly one cycle, excAddr<=redirectTarget.
- halt=1 (no trap/redirect):
  - pc holds and no new load occurs.
  - The slot still drains: if outValid && outReady then outValid<=0.
  - Fetch resumes at the same pc the cycle after halt falls.
- Normal (advance=1):
  - outInstr<=fetchInstr, outPc<=pc, outValid<=1, pc<=pc+4.
  - pc+4 wraps modulo 2^ADDR_WIDTH; no flag.
- Stall (advance=0): pc, outInstr, outPc, outValid all hold.
  - outInstr/outPc must not change while outValid=1 && outReady=0.
- Steady state with outReady tied 1: one instruction per cycle, first valid on the first edge after reset release.
- issueCount:
  - Increments on each cycle with outValid && outReady, including a cycle where a flush also occurs; the handshake counts.
  - Holds at max value.
- excMisaligned is low in every cycle not described above.

Test Plan:
- Reset release, memory returns addr-based pattern (instr=addr^32'hA5A5_0000), outReady=1 -> outPc 0,4,8,12 on consecutive cycles, outValid=1 from first edge, issueCount=4 after 4 handshakes.
- outReady=0 for 3 cycles with slot at outPc=8 -> outPc/outInstr hold at 8; fetchAddr holds at 12; on outReady=1 slot advances to 12 next edge.
- redirectValid with target 32'h0000_0040 while outPc=8 valid -> next edge outValid=0, fetchAddr=0x40; following edge outPc=0x40 valid.
- redirectValid with target 32'h0000_0042 -> excMisaligned=1 one cycle, excAddr=0x42, fetchAddr=TRAP_VECTOR (0x100), outValid=0.
- trapValid and redirectValid (target 0x80) same cycle -> pc=0x100, redirect ignored; pc at FFFF_FFFC with advance -> next pc=0.
- halt=1 with valid slot and outReady=1 -> slot empties, pc frozen; assert rst mid-halt -> all outputs at reset values, pc=RESET_VECTOR.
